fifo_ctrl_lvl: RTL and testbench
================================

Name: fifo_ctrl_lvl

Overview:
Parametrised FIFO pointer/status controller, the successor to the basic FIFO controller. It drives the address and enable pins of an external dual-port register file or BRAM. Beyond that it provides an occupancy count, parametrised almost-full/almost-empty thresholds, a synchronous flush, sticky overflow/underflow error flags, and correct simultaneous read/write at both boundaries. It sits between UART/CPU I/O producers and consumers and the FIFO storage array.

Parameters:
ADDR_WIDTH, 4, address bits; DEPTH = 2**ADDR_WIDTH entries (ADDR_WIDTH >= 2).
AF_LEVEL, 2**ADDR_WIDTH - 2, almost_full asserted when count >= AF_LEVEL (1..DEPTH).
AE_LEVEL, 2, almost_empty asserted when count <= AE_LEVEL (0..DEPTH-1).

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
clr  input  1  synchronous flush: empties the FIFO
wr  input  1  write request
rd  input  1  read request
err_clr  input  1  clears the sticky error flags
wr_en  output  1  accepted write this cycle (combinational), drives RAM write enable
rd_en  output  1  accepted read this cycle (combinational)
wr_addr  output  ADDR_WIDTH  write pointer (registered)
rd_addr  output  ADDR_WIDTH  read pointer (registered)
count  output  ADDR_WIDTH+1  occupancy, 0..DEPTH (registered)
full  output  1  count == DEPTH (registered)
empty  output  1  count == 0 (registered)
almost_full  output  1  count >= AF_LEVEL (registered)
almost_empty  output  1  count <= AE_LEVEL (registered)
overflow  output  1  sticky: a write was refused
underflow  output  1  sticky: a read was refused

Behaviour:
- Clocking and reset: clk is the only clock. reset is asynchronous and active-high; it takes effect immediately, including mid-operation.
- Reset values: wr_addr=0, rd_addr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0.
- Acceptance, combinational, no clr:
  - rd_en = rd & ~empty.
  - wr_en = wr & (~full | rd_en).
  - When full, a simultaneous rd+wr performs both operations; count is unchanged.
  - When empty, a simultaneous rd+wr performs the write only; count goes 0->1 and rd_addr holds.
- Pointers:
  - wr_addr increments by 1 on wr_en; rd_addr increments by 1 on rd_en.
  - Both wrap modulo DEPTH, e.g. DEPTH-1 -> 0, with no extra bit.
- Count: count_next = count + wr_en - rd_en, computed at ADDR_WIDTH+1 bits. It never exceeds DEPTH and never goes below 0.
- Status flags: full, empty, almost_full and almost_empty are registered from count_next. They reflect the new occupancy on the cycle after the accepting edge, with no lag beyond one clock.
- Storage latency: the RAM writes data at wr_addr on the same edge that wr_en is high. Read data at rd_addr is valid to the consumer while empty=0; the RAM read latency belongs to the consumer.
- Errors:
  - overflow sets on any cycle with wr & ~wr_en; underflow sets on any cycle with rd & ~rd_en.
  - Both flags hold until err_clr. If set and clear happen in the same cycle, set wins.
  - clr does not clear the error flags.
- Flush (clr=1):
  - wr_en=0 and rd_en=0 that cycle; wr and rd are ignored and do not set error flags.
  - On the next edge: pointers=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0.
- Idle: with wr=rd=0 all state holds.
- No state machine beyond the pointer/count registers. Flags are pure functions of count_next, so they are always mutually consistent.

Test Plan:
- Fill: reset, then 16 write cycles (ADDR_WIDTH=4). Required:
  - count steps 0->16.
  - almost_empty drops after the 3rd write.
  - almost_full rises after the 14th write.
  - full=1 after the 16th; wr_addr wraps to 0.
  - A 17th write gives wr_en=0 and overflow=1, with count still 16.
- Drain and underflow: from full, 16 reads. Required:
  - rd_addr wraps to 0, empty=1, count=0.
  - A 17th read gives rd_en=0 and underflow=1.
  - err_clr then clears underflow; err_clr in the same cycle as a new bad read leaves underflow=1.
- Simultaneous at boundaries:
  - Empty + rd&wr: wr_en=1, rd_en=0, count=1.
  - Full + rd&wr: both enables=1, count stays 16, full stays 1, both pointers advance by 1.
- Flush: at count=9 assert clr together with wr=1. Required: wr_en=0, and next cycle count=0, empty=1, pointers=0, overflow unchanged.
- Async reset mid-operation: assert reset between clock edges at count=5 with overflow=1. Required: all outputs go to reset values before the next edge.
- Random stream: 2000 cycles of random wr/rd/clr checked against a scoreboard model. Required: count, all flags and both pointers match the model every cycle, and there is never a lost or duplicated entry.

Source files
------------

// File: rtl/fifo_ctrl_lvl_if.sv
// Handshake and status bundle between a FIFO producer/consumer side and the
// fifo_ctrl_lvl pointer controller.
interface fifo_ctrl_lvl_if #(
    parameter int ADDR_WIDTH = 4
);
    logic                  clr;
    logic                  wr;
    logic                  rd;
    logic                  err_clr;
    logic                  wr_en;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [ADDR_WIDTH:0]   count;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output clr, wr, rd, err_clr,
        input  wr_en, rd_en, wr_addr, rd_addr, count,
        input  full, empty, almost_full, almost_empty, overflow, underflow
    );

    modport slave (
        input  clr, wr, rd, err_clr,
        output wr_en, rd_en, wr_addr, rd_addr, count,
        output full, empty, almost_full, almost_empty, overflow, underflow
    );
endinterface

// File: rtl/fifo_ctrl_lvl.sv
// FIFO pointer/status controller for an external dual-port RAM: occupancy count,
// almost-full/almost-empty thresholds, synchronous flush and sticky error flags.
module fifo_ctrl_lvl #(
    parameter int ADDR_WIDTH = 4,
    parameter int AF_LEVEL   = 2**ADDR_WIDTH - 2,
    parameter int AE_LEVEL   = 2
) (
    input logic            clk,
    input logic            reset,
    fifo_ctrl_lvl_if.slave bus
);
    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(2**ADDR_WIDTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  af_q, af_d;
    logic                  ae_q, ae_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  wr_en;
    logic                  rd_en;

    always_comb begin
        // A read frees a slot in the same cycle, so a full FIFO still accepts rd+wr.
        rd_en = bus.rd & ~bus.clr & ~empty_q;
        wr_en = bus.wr & ~bus.clr & (~full_q | rd_en);

        wr_addr_d = wr_addr_q;
        rd_addr_d = rd_addr_q;
        count_d   = count_q;
        if (bus.clr) begin
            wr_addr_d = '0;
            rd_addr_d = '0;
            count_d   = '0;
        end else begin
            wr_addr_d = wr_addr_q + ADDR_WIDTH'(wr_en);
            rd_addr_d = rd_addr_q + ADDR_WIDTH'(rd_en);
            count_d   = count_q + CW'(wr_en) - CW'(rd_en);
        end

        full_d  = (count_d == DEPTH_C);
        empty_d = (count_d == '0);
        af_d    = (count_d >= AF_C);
        ae_d    = (count_d <= AE_C);

        // Set beats clear; requests during a flush are ignored, not refused.
        overflow_d  = (overflow_q  & ~bus.err_clr) | (bus.wr & ~wr_en & ~bus.clr);
        underflow_d = (underflow_q & ~bus.err_clr) | (bus.rd & ~rd_en & ~bus.clr);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_addr_q   <= '0;
            rd_addr_q   <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            af_q        <= 1'b0;
            ae_q        <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_addr_q   <= wr_addr_d;
            rd_addr_q   <= rd_addr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            af_q        <= af_d;
            ae_q        <= ae_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.wr_en        = wr_en;
    assign bus.rd_en        = rd_en;
    assign bus.wr_addr      = wr_addr_q;
    assign bus.rd_addr      = rd_addr_q;
    assign bus.count        = count_q;
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = af_q;
    assign bus.almost_empty = ae_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_fifo_ctrl_lvl.sv
// Testbench for fifo_ctrl_lvl: vector table for fill/drain/error corners, hand
// sequences for boundaries, flush and async reset, then a random stream.
module tb_fifo_ctrl_lvl;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int AF    = DEPTH - 2;
    localparam int AE    = 2;

    logic clk;
    logic reset;

    fifo_ctrl_lvl_if #(.ADDR_WIDTH(AW)) bus ();

    fifo_ctrl_lvl #(.ADDR_WIDTH(AW), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit wr, rd, clr, err_clr;
        bit exp_wr_en, exp_rd_en;
        int exp_count, exp_wa, exp_ra;
        bit exp_full, exp_empty, exp_af, exp_ae, exp_ovf, exp_udf;
    } vec_t;

    typedef struct {
        int cnt, wa, ra;
        bit full, empty, af, ae, ovf, udf;
    } exp_t;

    int   passed = 0;
    int   total  = 0;
    int   m_cnt, m_wa, m_ra;
    bit   m_ovf, m_udf;
    int   mem [DEPTH];
    int   data_q [$];
    exp_t sb_q [$];
    int   tag = 1;
    int   last_wr_en, last_rd_en;
    vec_t vecs [$];

    function automatic void chk(string name, int act, int exp);
        total++;
        if (act != exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
        else passed++;
    endfunction

    function automatic void model_reset();
        m_cnt = 0; m_wa = 0; m_ra = 0; m_ovf = 0; m_udf = 0;
        data_q.delete();
        sb_q.delete();
    endfunction

    function automatic void check_state(string tagname, exp_t e);
        chk({tagname, "_count"}, int'(bus.count), e.cnt);
        chk({tagname, "_wr_addr"}, int'(bus.wr_addr), e.wa);
        chk({tagname, "_rd_addr"}, int'(bus.rd_addr), e.ra);
        chk({tagname, "_full"}, int'(bus.full), int'(e.full));
        chk({tagname, "_empty"}, int'(bus.empty), int'(e.empty));
        chk({tagname, "_afull"}, int'(bus.almost_full), int'(e.af));
        chk({tagname, "_aempty"}, int'(bus.almost_empty), int'(e.ae));
        chk({tagname, "_overflow"}, int'(bus.overflow), int'(e.ovf));
        chk({tagname, "_underflow"}, int'(bus.underflow), int'(e.udf));
    endfunction

    // Called just after a rising edge; returns just after the next rising edge.
    task automatic step(input bit w, input bit r, input bit c, input bit e);
        bit   mr, mw;
        int   exp_tag;
        exp_t x;
        bus.wr = w; bus.rd = r; bus.clr = c; bus.err_clr = e;
        @(negedge clk);
        mr = r && !c && (m_cnt != 0);
        mw = w && !c && ((m_cnt != DEPTH) || mr);
        last_wr_en = int'(bus.wr_en);
        last_rd_en = int'(bus.rd_en);
        chk("wr_en", last_wr_en, int'(mw));
        chk("rd_en", last_rd_en, int'(mr));
        if (bus.rd_en) begin
            exp_tag = (data_q.size() > 0) ? data_q.pop_front() : -1;
            chk("rd_data", mem[bus.rd_addr], exp_tag);
        end
        if (bus.wr_en) begin
            mem[bus.wr_addr] = tag;
            data_q.push_back(tag);
            tag++;
        end
        if (c) data_q.delete();
        m_ovf = (m_ovf && !e) || (w && !mw && !c);
        m_udf = (m_udf && !e) || (r && !mr && !c);
        if (c) begin
            m_cnt = 0; m_wa = 0; m_ra = 0;
        end else begin
            if (mw) begin m_wa = (m_wa + 1) % DEPTH; m_cnt++; end
            if (mr) begin m_ra = (m_ra + 1) % DEPTH; m_cnt--; end
        end
        x.cnt = m_cnt; x.wa = m_wa; x.ra = m_ra;
        x.full = (m_cnt == DEPTH); x.empty = (m_cnt == 0);
        x.af = (m_cnt >= AF); x.ae = (m_cnt <= AE);
        x.ovf = m_ovf; x.udf = m_udf;
        sb_q.push_back(x);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) chk("sb_empty", 1, 0);
        else check_state("sb", sb_q.pop_front());
    endtask

    function automatic vec_t mk(bit w, bit r, bit c, bit e, bit we, bit re, int cnt,
                                int wa, int ra, bit ovf, bit udf);
        vec_t v;
        v.wr = w; v.rd = r; v.clr = c; v.err_clr = e;
        v.exp_wr_en = we; v.exp_rd_en = re;
        v.exp_count = cnt; v.exp_wa = wa; v.exp_ra = ra;
        v.exp_full = (cnt == 16); v.exp_empty = (cnt == 0);
        v.exp_af = (cnt >= 14); v.exp_ae = (cnt <= 2);
        v.exp_ovf = ovf; v.exp_udf = udf;
        return v;
    endfunction

    initial begin
        // Fill: 16 accepted writes, then a refused 17th.
        for (int i = 1; i <= 16; i++) vecs.push_back(mk(1, 0, 0, 0, 1, 0, i, i % 16, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 16, 0, 0, 1, 0));
        // Drain: 16 accepted reads, then a refused 17th.
        for (int j = 1; j <= 16; j++) vecs.push_back(mk(0, 1, 0, 0, 0, 1, 16 - j, 0, j % 16, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1));
        // Empty with rd+wr: write only, and the read is refused.
        vecs.push_back(mk(1, 1, 0, 0, 1, 0, 1, 1, 0, 0, 1));

        bus.wr = 0; bus.rd = 0; bus.clr = 0; bus.err_clr = 0;
        last_wr_en = 0; last_rd_en = 0;
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_count", int'(bus.count), 0);
        chk("rst_empty", int'(bus.empty), 1);
        chk("rst_aempty", int'(bus.almost_empty), 1);
        chk("rst_full", int'(bus.full), 0);
        chk("rst_afull", int'(bus.almost_full), 0);
        chk("rst_ptrs", int'({bus.wr_addr, bus.rd_addr}), 0);
        chk("rst_errs", int'({bus.overflow, bus.underflow}), 0);

        foreach (vecs[k]) begin
            vec_t v;
            string n;
            v = vecs[k];
            n = $sformatf("vec%0d", k);
            step(v.wr, v.rd, v.clr, v.err_clr);
            chk({n, "_wr_en"}, last_wr_en, int'(v.exp_wr_en));
            chk({n, "_rd_en"}, last_rd_en, int'(v.exp_rd_en));
            chk({n, "_count"}, int'(bus.count), v.exp_count);
            chk({n, "_wr_addr"}, int'(bus.wr_addr), v.exp_wa);
            chk({n, "_rd_addr"}, int'(bus.rd_addr), v.exp_ra);
            chk({n, "_flags"}, int'({bus.full, bus.empty, bus.almost_full, bus.almost_empty}),
                int'({v.exp_full, v.exp_empty, v.exp_af, v.exp_ae}));
            chk({n, "_errs"}, int'({bus.overflow, bus.underflow}), int'({v.exp_ovf, v.exp_udf}));
        end

        // Full with rd+wr: both accepted, count and full unchanged, pointers advance.
        step(0, 0, 0, 1);
        repeat (15) step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("full_count", int'(bus.count), 16);
        step(1, 1, 0, 0);
        chk("fullrw_wr_en", last_wr_en, 1);
        chk("fullrw_rd_en", last_rd_en, 1);
        chk("fullrw_count", int'(bus.count), 16);
        chk("fullrw_full", int'(bus.full), 1);
        chk("fullrw_wr_addr", int'(bus.wr_addr), 1);
        chk("fullrw_rd_addr", int'(bus.rd_addr), 1);

        // Flush at count 9 with a concurrent write; overflow survives.
        repeat (7) step(0, 1, 0, 0);
        chk("preflush_count", int'(bus.count), 9);
        step(1, 0, 1, 0);
        chk("flush_wr_en", last_wr_en, 0);
        chk("flush_count", int'(bus.count), 0);
        chk("flush_empty", int'(bus.empty), 1);
        chk("flush_ptrs", int'({bus.wr_addr, bus.rd_addr}), 0);
        chk("flush_overflow", int'(bus.overflow), 1);

        // Async reset between edges at count 5 with overflow set.
        repeat (5) step(1, 0, 0, 0);
        chk("prereset_count", int'(bus.count), 5);
        bus.wr = 0; bus.rd = 0; bus.clr = 0; bus.err_clr = 0;
        #2 reset = 1'b1;
        #1;
        chk("async_count", int'(bus.count), 0);
        chk("async_ptrs", int'({bus.wr_addr, bus.rd_addr}), 0);
        chk("async_flags", int'({bus.full, bus.empty, bus.almost_full, bus.almost_empty}), 5);
        chk("async_errs", int'({bus.overflow, bus.underflow}), 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Random stream against the model and scoreboard.
        for (int c = 0; c < 2000; c++) begin
            step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                 ($urandom_range(0, 49) == 0), ($urandom_range(0, 19) == 0));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
